// File: rtl/vga_circle_ctrl.sv
// Frame-synchronous bouncing-circle motion controller: computes centre/radius once per
// FRAME_DIV frames and commits them in vertical blanking. Optional colour port: VGA_CIRCLE_COLOR_EN.

module vga_circle_axis #(
  parameter int ACTIVE = 640,
  parameter int STEP   = 2
) (
  input  logic [9:0] pos,
  input  logic       dir_neg,
  input  logic [9:0] rad,
  input  logic       run_n,
  output logic [9:0] npos,
  output logic       flip
);
  localparam logic [10:0] LAST   = 11'(ACTIVE - 1);
  localparam logic [10:0] STEP_W = 11'(STEP);

  logic [10:0] step, hi, sum, lo;

  // Clamp even when frozen so a radius change cannot push the circle off-screen;
  // only a moving axis is allowed to reverse.
  always_comb begin
    step = run_n ? STEP_W : 11'd0;
    hi   = LAST - {1'b0, rad};
    sum  = {1'b0, pos} + step;
    lo   = {1'b0, rad} + step;
    npos = pos;
    flip = 1'b0;
    if (!dir_neg) begin
      if (sum > hi) begin
        npos = hi[9:0];
        flip = run_n;
      end else begin
        npos = sum[9:0];
      end
    end else begin
      if ({1'b0, pos} < lo) begin
        npos = rad;
        flip = run_n;
      end else begin
        npos = pos - step[9:0];
      end
    end
  end
endmodule

module vga_circle_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int R_SMALL   = 40,
  parameter int R_BIG     = 80,
  parameter int STEP_X    = 2,
  parameter int STEP_Y    = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync_in,
  input  logic       run,
  input  logic       big,
  output logic [9:0] cx,
  output logic [9:0] cy,
  output logic [9:0] radius,
  output logic       frame_tick,
  output logic       bounce
`ifdef VGA_CIRCLE_COLOR_EN
  ,
  output logic [11:0] colour
`endif
);
  localparam logic [7:0] DIV_LAST  = 8'(FRAME_DIV - 1);
  localparam logic [9:0] CX_RST    = 10'(H_ACTIVE / 2);
  localparam logic [9:0] CY_RST    = 10'(V_ACTIVE / 2);
  localparam logic [9:0] R_SMALL_W = 10'(R_SMALL);
  localparam logic [9:0] R_BIG_W   = 10'(R_BIG);

  typedef enum logic [1:0] {S_WAIT, S_CALC_X, S_CALC_Y, S_COMMIT} state_t;

  state_t     state;
  logic       vsync_d;
  logic [7:0] frame_cnt;
  logic [9:0] r_n;
  logic       run_n;
  logic       dir_x, dir_y;       // 1 = moving toward lower coordinates
  logic [9:0] nx, ny;            // shadow geometry, committed together
  logic       flip_x, flip_y;
  logic [9:0] ax_pos, ay_pos;
  logic       ax_flip, ay_flip;
  logic       vs_fall;

  assign vs_fall = vsync_d & ~vsync_in;

  vga_circle_axis #(.ACTIVE(H_ACTIVE), .STEP(STEP_X)) u_axis_x (
    .pos(cx), .dir_neg(dir_x), .rad(r_n), .run_n(run_n), .npos(ax_pos), .flip(ax_flip)
  );

  vga_circle_axis #(.ACTIVE(V_ACTIVE), .STEP(STEP_Y)) u_axis_y (
    .pos(cy), .dir_neg(dir_y), .rad(r_n), .run_n(run_n), .npos(ay_pos), .flip(ay_flip)
  );

`ifdef VGA_CIRCLE_COLOR_EN
  function automatic logic [11:0] colour_next(input logic [11:0] c);
    case (c)
      12'hF00: colour_next = 12'h0F0;
      12'h0F0: colour_next = 12'h00F;
      12'h00F: colour_next = 12'hFF0;
      default: colour_next = 12'hF00;
    endcase
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_WAIT;
      vsync_d    <= 1'b1;
      frame_cnt  <= 8'd0;
      r_n        <= R_SMALL_W;
      run_n      <= 1'b0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      nx         <= CX_RST;
      ny         <= CY_RST;
      flip_x     <= 1'b0;
      flip_y     <= 1'b0;
      cx         <= CX_RST;
      cy         <= CY_RST;
      radius     <= R_SMALL_W;
      frame_tick <= 1'b0;
      bounce     <= 1'b0;
`ifdef VGA_CIRCLE_COLOR_EN
      colour     <= 12'hF00;
`endif
    end else begin
      vsync_d    <= vsync_in;
      frame_tick <= 1'b0;
      bounce     <= 1'b0;
      case (state)
        S_WAIT: begin
          // Edges arriving mid-sequence are dropped and do not advance the divider.
          if (vs_fall) begin
            frame_cnt <= (frame_cnt == DIV_LAST) ? 8'd0 : frame_cnt + 8'd1;
            if (frame_cnt == DIV_LAST) begin
              r_n   <= big ? R_BIG_W : R_SMALL_W;
              run_n <= run;
              state <= S_CALC_X;
            end
          end
        end
        S_CALC_X: begin
          nx     <= ax_pos;
          flip_x <= ax_flip;
          state  <= S_CALC_Y;
        end
        S_CALC_Y: begin
          ny     <= ay_pos;
          flip_y <= ay_flip;
          state  <= S_COMMIT;
        end
        S_COMMIT: begin
          cx         <= nx;
          cy         <= ny;
          radius     <= r_n;
          frame_tick <= 1'b1;
          bounce     <= flip_x | flip_y;
          dir_x      <= dir_x ^ flip_x;
          dir_y      <= dir_y ^ flip_y;
`ifdef VGA_CIRCLE_COLOR_EN
          if (flip_x | flip_y) colour <= colour_next(colour);
`endif
          state      <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_circle_ctrl.sv
// Scoreboard bench for vga_circle_ctrl: two instances (FRAME_DIV 1 and 3) against a frame-level model.
module tb_vga_circle_ctrl;
  localparam int HA = 100, VA = 100, RS = 10, RB = 30, SX = 2, SY = 1;

  logic clk = 1'b0;
  logic reset, vsync_in, run, big;
  logic [9:0] cx0, cy0, r0, cx1, cy1, r1;
  logic tick0, bnc0, tick1, bnc1;
`ifdef VGA_CIRCLE_COLOR_EN
  logic [11:0] col0, col1;
`endif

  always #20 clk = ~clk;

  vga_circle_ctrl #(.H_ACTIVE(HA), .V_ACTIVE(VA), .R_SMALL(RS), .R_BIG(RB), .FRAME_DIV(1)) dut (
    .clk(clk), .reset(reset), .vsync_in(vsync_in), .run(run), .big(big),
    .cx(cx0), .cy(cy0), .radius(r0), .frame_tick(tick0), .bounce(bnc0)
`ifdef VGA_CIRCLE_COLOR_EN
    , .colour(col0)
`endif
  );

  vga_circle_ctrl #(.H_ACTIVE(HA), .V_ACTIVE(VA), .R_SMALL(RS), .R_BIG(RB), .FRAME_DIV(3)) dut_div3 (
    .clk(clk), .reset(reset), .vsync_in(vsync_in), .run(run), .big(big),
    .cx(cx1), .cy(cy1), .radius(r1), .frame_tick(tick1), .bounce(bnc1)
`ifdef VGA_CIRCLE_COLOR_EN
    , .colour(col1)
`endif
  );

  typedef struct { int cx; int cy; int r; int bnc; int col; } exp_t;

  int checks = 0, errors = 0;
  exp_t q0[$], q1[$];
  exp_t cur0, cur1;
  int m_cx[2], m_cy[2], m_dx[2], m_dy[2], m_fc[2], m_ci[2];
  int divs[2] = '{1, 3};
  int colours[4] = '{'hF00, 'h0F0, 'h00F, 'hFF0};
  int t0 = 0, t1 = 0;
  int last_bnc;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t rst_exp();
    exp_t e;
    e.cx = HA / 2; e.cy = VA / 2; e.r = RS; e.bnc = 0; e.col = 'hF00;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cx[i] = HA / 2; m_cy[i] = VA / 2; m_dx[i] = 1; m_dy[i] = 1; m_fc[i] = 0; m_ci[i] = 0;
    end
    q0.delete(); q1.delete();
    cur0 = rst_exp(); cur1 = rst_exp();
  endtask

  // One axis move: advance, then clamp against the edge it is heading toward.
  task automatic axis(input int act, input int st, input int r, input int rn, input int p,
                      input int d, output int np, output int nd, output int fl);
    fl = 0;
    if (d > 0) begin
      np = p + st;
      if (np > act - 1 - r) begin np = act - 1 - r; fl = rn; end
    end else begin
      np = p - st;
      if (np < r) begin np = r; fl = rn; end
    end
    nd = fl ? -d : d;
  endtask

  task automatic model_edge();
    int r, nx, ny, ndx, ndy, fx, fy;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (m_fc[i] == divs[i] - 1) begin
        m_fc[i] = 0;
        r = big ? RB : RS;
        axis(HA, run ? SX : 0, r, int'(run), m_cx[i], m_dx[i], nx, ndx, fx);
        axis(VA, run ? SY : 0, r, int'(run), m_cy[i], m_dy[i], ny, ndy, fy);
        m_cx[i] = nx; m_dx[i] = ndx; m_cy[i] = ny; m_dy[i] = ndy;
        if (fx != 0 || fy != 0) m_ci[i] = (m_ci[i] + 1) % 4;
        e.cx = nx; e.cy = ny; e.r = r; e.bnc = (fx != 0 || fy != 0) ? 1 : 0; e.col = colours[m_ci[i]];
        if (i == 0) q0.push_back(e); else q1.push_back(e);
      end else begin
        m_fc[i]++;
      end
    end
  endtask

  // Monitor: pops on each tick, otherwise checks outputs hold the last commit.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (tick0) begin
        t0++;
        if (q0.size() == 0) chk("d0_unexpected_tick", int'(tick0), 0);
        else begin
          e = q0.pop_front();
          chk("d0_cx", int'(cx0), e.cx); chk("d0_cy", int'(cy0), e.cy);
          chk("d0_radius", int'(r0), e.r); chk("d0_bounce", int'(bnc0), e.bnc);
`ifdef VGA_CIRCLE_COLOR_EN
          chk("d0_colour", int'(col0), e.col);
`endif
          cur0 = e;
        end
      end else begin
        chk("d0_hold_cx", int'(cx0), cur0.cx); chk("d0_hold_cy", int'(cy0), cur0.cy);
        chk("d0_hold_radius", int'(r0), cur0.r); chk("d0_bounce_idle", int'(bnc0), 0);
`ifdef VGA_CIRCLE_COLOR_EN
        chk("d0_hold_colour", int'(col0), cur0.col);
`endif
      end
      if (tick1) begin
        t1++;
        if (q1.size() == 0) chk("d3_unexpected_tick", int'(tick1), 0);
        else begin
          e = q1.pop_front();
          chk("d3_cx", int'(cx1), e.cx); chk("d3_cy", int'(cy1), e.cy);
          chk("d3_radius", int'(r1), e.r); chk("d3_bounce", int'(bnc1), e.bnc);
`ifdef VGA_CIRCLE_COLOR_EN
          chk("d3_colour", int'(col1), e.col);
`endif
          cur1 = e;
        end
      end else begin
        chk("d3_hold_cx", int'(cx1), cur1.cx); chk("d3_hold_cy", int'(cy1), cur1.cy);
        chk("d3_hold_radius", int'(r1), cur1.r); chk("d3_bounce_idle", int'(bnc1), 0);
      end
    end
  end

  // One frame: vsync falls, the FRAME_DIV=1 instance must tick exactly at E+4.
  task automatic frame(input int hi_len);
    int k, got;
    @(posedge clk); #1 vsync_in = 1'b0;
    model_edge();
    k = 0; got = 0;
    while (k < 10 && got == 0) begin
      @(negedge clk);
      if (tick0) begin got = 1; last_bnc = int'(bnc0); end
      else k++;
    end
    chk("tick_latency", k, 4);
    @(posedge clk); #1 vsync_in = 1'b1;
    repeat (hi_len) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_cx"}, int'(cx0), 50); chk({nm, "_cy"}, int'(cy0), 50);
    chk({nm, "_radius"}, int'(r0), 10); chk({nm, "_tick"}, int'(tick0), 0);
    chk({nm, "_bounce"}, int'(bnc0), 0);
    chk({nm, "_d3_cx"}, int'(cx1), 50); chk({nm, "_d3_radius"}, int'(r1), 10);
  endtask

  initial begin
    int sx, sy, tb;
    reset = 1'b0; vsync_in = 1'b1; run = 1'b0; big = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");

    // First frame from reset, then run toward the right edge.
    @(posedge clk); #1 run = 1'b1; big = 1'b0;
    frame(12);
    chk("f1_cx", int'(cx0), 52); chk("f1_cy", int'(cy0), 51);
    for (int f = 2; f <= 19; f++) frame(10);
    chk("f19_cx", int'(cx0), 88);
    frame(10);
    chk("f20_cx", int'(cx0), 89); chk("f20_bounce", last_bnc, 1);
`ifdef VGA_CIRCLE_COLOR_EN
    chk("f20_colour", int'(col0), 'h0F0);
`endif
    frame(10);
    chk("f21_cx", int'(cx0), 87); chk("f21_bounce", last_bnc, 0);

    // Radius growth near the edge clamps without reversing.
    do_reset(2);
    for (int f = 1; f <= 19; f++) frame(10);
    chk("r19_cx", int'(cx0), 88);
    run = 1'b0; big = 1'b1;
    frame(10);
    chk("grow_cx", int'(cx0), 69); chk("grow_radius", int'(r0), 30); chk("grow_bounce", last_bnc, 0);
    run = 1'b1; big = 1'b0;
    frame(10);
    chk("after_grow_cx", int'(cx0), 71);

    // Frozen: ticks continue, geometry stays put.
    run = 1'b0; big = 1'b0;
    sx = int'(cx0); sy = int'(cy0); tb = t0;
    for (int f = 0; f < 5; f++) begin
      frame(10);
      chk("freeze_cx", int'(cx0), sx); chk("freeze_cy", int'(cy0), sy);
      chk("freeze_bounce", last_bnc, 0);
    end
    chk("freeze_ticks", t0 - tb, 5);

    // Randomised motion, including radius flips and pauses.
    for (int f = 0; f < 60; f++) begin
      run = ($urandom_range(3) != 0);
      big = 1'($urandom_range(1));
      frame($urandom_range(8, 30));
    end

    // Divider: FRAME_DIV=3 instance ticks on frames 3 and 6 only.
    do_reset(3);
    run = 1'b1; big = 1'b0;
    tb = t1;
    for (int f = 1; f <= 6; f++) begin
      frame(10);
      chk("div3_ticks", t1 - tb, f / 3);
    end

    // Reset in E+2 aborts the sequence in flight.
    tb = t0;
    @(posedge clk); #1 vsync_in = 1'b0;
    model_edge();
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; vsync_in = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("abort_no_tick", t0 - tb, 0);
    chk_reset_vals("abort");

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
